// File: rtl/pipe_buf_pkg.sv
// Shared stage-bus widths for the pipeline stage modules and their pipe_buf links.
package pipe_buf_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 64;
    localparam int REG_ADDR_WIDTH = 5;

    // Per-link bus widths carried by pipe_buf instances between stages.
    localparam int IF_ID_WIDTH  = 2 * DATA_WIDTH;                      // pc + instruction
    localparam int ID_EX_WIDTH  = 3 * DATA_WIDTH + REG_ADDR_WIDTH;     // pc, two operands, rd
    localparam int EX_MEM_WIDTH = 2 * DATA_WIDTH + REG_ADDR_WIDTH;     // result, store data, rd
    localparam int MEM_WB_WIDTH = DATA_WIDTH + REG_ADDR_WIDTH;         // writeback value, rd

endpackage

// File: rtl/pipe_buf_ram.sv
// DEPTH x DATA_WIDTH register array, one synchronous write port, one combinational read port.
// Contents are not reset; entries are only ever read after being written.
module pipe_buf_ram
    import pipe_buf_pkg::*;
#(
    parameter int DATA_WIDTH = pipe_buf_pkg::DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_buf.sv
// Inter-stage pipeline buffer: circular FIFO with optional same-cycle fall-through
// when empty. in_ready depends only on held state and flush, never on out_ready.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module pipe_buf
    import pipe_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = pipe_buf_pkg::DATA_WIDTH,
    parameter int DEPTH       = 2,
    parameter int FALLTHROUGH = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_bus,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_bus,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam bit FT = (FALLTHROUGH != 0);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  bypass;
    logic                  in_fire;
    logic                  out_fire;
    logic                  push;
    logic                  pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign bypass = FT && empty;

    // rst_n gates the handshakes so nothing is offered or accepted while in reset.
    assign in_ready  = rst_n && !full && !flush;
    assign out_valid = rst_n && !flush && (bypass ? in_valid : !empty);
    assign out_bus   = bypass ? in_bus : rd_data;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // A fall-through word consumed in the same cycle is never stored.
    assign push     = in_fire && !(bypass && out_fire);
    assign pop      = out_fire && !bypass;

    // Pointer and occupancy update; flush clears everything at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    pipe_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_bus),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pipe_buf.sv
// Directed bench for pipe_buf: three instances (DEPTH=2 registered, DEPTH=4 registered,
// DEPTH=4 fall-through) sharing clock and reset.
module tb_pipe_buf;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance a: DEPTH=2, FALLTHROUGH=0
    logic       a_iv, a_ir, a_ov, a_or, a_fl, a_fu, a_em;
    logic [7:0] a_ib, a_ob;
    logic [1:0] a_cnt;
    // Instance b: DEPTH=4, FALLTHROUGH=0
    logic       b_iv, b_ir, b_ov, b_or, b_fl, b_fu, b_em;
    logic [7:0] b_ib, b_ob;
    logic [2:0] b_cnt;
    // Instance c: DEPTH=4, FALLTHROUGH=1
    logic       c_iv, c_ir, c_ov, c_or, c_fl, c_fu, c_em;
    logic [7:0] c_ib, c_ob;
    logic [2:0] c_cnt;

    pipe_buf #(.DATA_WIDTH(8), .DEPTH(2), .FALLTHROUGH(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_bus(a_ib),
        .out_valid(a_ov), .out_ready(a_or), .out_bus(a_ob), .flush(a_fl),
        .count(a_cnt), .full(a_fu), .empty(a_em));

    pipe_buf #(.DATA_WIDTH(8), .DEPTH(4), .FALLTHROUGH(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_bus(b_ib),
        .out_valid(b_ov), .out_ready(b_or), .out_bus(b_ob), .flush(b_fl),
        .count(b_cnt), .full(b_fu), .empty(b_em));

    pipe_buf #(.DATA_WIDTH(8), .DEPTH(4), .FALLTHROUGH(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_bus(c_ib),
        .out_valid(c_ov), .out_ready(c_or), .out_bus(c_ob), .flush(c_fl),
        .count(c_cnt), .full(c_fu), .empty(c_em));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  sent;
        int  rcv;
        bit  in_ok;
        bit  out_ok;

        rst_n = 1'b0;
        a_iv = 0; a_or = 0; a_fl = 0; a_ib = '0;
        b_iv = 0; b_or = 0; b_fl = 0; b_ib = '0;
        c_iv = 1; c_or = 1; c_fl = 0; c_ib = 8'h11;

        // During reset, before any clock edge.
        #3;
        chk("rst_in_ready", a_ir, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_empty", a_em, 1);
        chk("rst_full", a_fu, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_ft_out_valid", c_ov, 0);
        c_iv = 0; c_or = 0;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", a_ir, 1);
        cycle();

        // DEPTH=2: push 0xA, 0xB with out_ready low, then drain.
        a_iv = 1; a_ib = 8'h0A;
        #1;
        chk("ft0_empty_no_valid", a_ov, 0);
        cycle();
        a_ib = 8'h0B;
        #1;
        chk("one_cycle_latency_valid", a_ov, 1);
        chk("one_cycle_latency_data", a_ob, 8'h0A);
        cycle();
        a_iv = 0;
        #1;
        chk("d2_count2", a_cnt, 2);
        chk("d2_full", a_fu, 1);
        chk("d2_in_ready_low", a_ir, 0);
        chk("d2_head", a_ob, 8'h0A);
        a_or = 1;
        cycle();
        chk("d2_second", a_ob, 8'h0B);
        chk("d2_count1", a_cnt, 1);
        cycle();
        chk("d2_empty", a_em, 1);
        chk("d2_drained_valid", a_ov, 0);
        a_or = 0;

        // DEPTH=4: stream 0..9 with out_ready toggling every cycle.
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 100 && rcv < 10; cyc++) begin
            b_iv = (sent < 10);
            b_ib = 8'(sent);
            b_or = cyc[0];
            #1;
            in_ok  = b_iv && b_ir;
            out_ok = b_ov && b_or;
            if (out_ok) begin
                chk("stream_data", 64'(b_ob), 64'(rcv));
                rcv++;
            end
            cycle();
            if (in_ok) sent++;
        end
        b_iv = 0; b_or = 0;
        chk("stream_received", 64'(rcv), 10);
        chk("stream_sent", 64'(sent), 10);
        #1;
        chk("stream_empty", b_em, 1);
        chk("stream_no_extra", b_ov, 0);

        // Full buffer with out_ready and in_valid both high.
        for (int i = 0; i < 4; i++) begin
            b_iv = 1; b_ib = 8'(8'h20 + i);
            cycle();
        end
        b_ib = 8'h99;
        b_or = 1;
        #1;
        chk("full_flag", b_fu, 1);
        chk("full_in_ready_low", b_ir, 0);
        chk("full_head", b_ob, 8'h20);
        cycle();
        b_iv = 0; b_or = 0;
        #1;
        chk("full_pop_count", b_cnt, 3);
        chk("full_pop_in_ready", b_ir, 1);
        chk("full_pop_next", b_ob, 8'h21);

        // Flush with count=3 and in_valid high.
        b_fl = 1; b_iv = 1; b_ib = 8'h77; b_or = 1;
        #1;
        chk("flush_in_ready", b_ir, 0);
        chk("flush_out_valid", b_ov, 0);
        cycle();
        b_fl = 0; b_iv = 0; b_or = 0;
        #1;
        chk("flush_count", b_cnt, 0);
        chk("flush_empty", b_em, 1);
        chk("flush_full", b_fu, 0);
        chk("flush_out_valid_after", b_ov, 0);
        b_iv = 1; b_ib = 8'h31;
        cycle();
        b_iv = 0;
        #1;
        chk("flush_ptr_reuse", b_ob, 8'h31);
        chk("flush_reuse_count", b_cnt, 1);

        // Fall-through instance.
        c_iv = 1; c_ib = 8'h55; c_or = 1;
        #1;
        chk("ft_bypass_valid", c_ov, 1);
        chk("ft_bypass_data", c_ob, 8'h55);
        cycle();
        c_iv = 0; c_or = 0;
        #1;
        chk("ft_bypass_count", c_cnt, 0);
        c_iv = 1; c_ib = 8'h66;
        #1;
        chk("ft_offer_data", c_ob, 8'h66);
        cycle();
        c_ib = 8'h77; c_or = 1;
        #1;
        chk("ft_stored_count", c_cnt, 1);
        chk("ft_nonempty_head", c_ob, 8'h66);
        cycle();
        c_iv = 0;
        #1;
        chk("ft_simul_count", c_cnt, 1);
        chk("ft_simul_next", c_ob, 8'h77);
        cycle();
        c_or = 0;
        chk("ft_drained", c_em, 1);

        // Asynchronous reset mid-operation with count=2.
        a_iv = 1; a_ib = 8'h41;
        cycle();
        a_ib = 8'h42;
        cycle();
        a_iv = 0;
        #1;
        chk("pre_async_count", a_cnt, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_count", a_cnt, 0);
        chk("async_out_valid", a_ov, 0);
        chk("async_empty", a_em, 1);
        chk("async_in_ready", a_ir, 0);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("after_async_count", a_cnt, 0);
        chk("after_async_in_ready", a_ir, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_buf.md
PIPE_BUF -- requirements
Module: pipe_buf

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the width of the inter-stage bus carried per entry.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the entry count; a power of two, at least 2.
REQ-003 The block SHALL have parameter FALLTHROUGH, default 0, meaning 1 = empty buffer passes input to output in the same cycle, 0 = every transfer is registered.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  the upstream stage offers in_bus.
REQ-007 in_ready  output  1  the buffer accepts in_bus this cycle.
REQ-008 in_bus  input  DATA_WIDTH  the upstream payload.
REQ-009 out_valid  output  1  out_bus holds a valid entry.
REQ-010 out_ready  input  1  the downstream stage consumes out_bus this cycle.
REQ-011 out_bus  output  DATA_WIDTH  the oldest entry, or in_bus when falling through.
REQ-012 flush  input  1  discard all held entries (redirect/exception).
REQ-013 count  output  $clog2(DEPTH+1)  the number of entries currently held.
REQ-014 full  output  1  count equals DEPTH.
REQ-015 empty  output  1  count equals 0.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-017 in_ready SHALL equal !full && !flush and SHALL NOT depend combinationally on out_ready.
REQ-018 Entries SHALL be delivered in strict FIFO order, unmodified.
REQ-019 Storage SHALL be a circular array with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-020 With FALLTHROUGH=0, out_valid SHALL equal !empty && !flush, out_bus SHALL be the entry at the read pointer, and input-to-output latency SHALL be 1 cycle.
REQ-021 With FALLTHROUGH=1 and empty, out_valid SHALL equal in_valid && !flush and out_bus SHALL equal in_bus; if out_ready is high, the word SHALL NOT be stored and count SHALL remain 0.
REQ-022 With FALLTHROUGH=1 and not empty, behaviour SHALL be identical to REQ-020.
REQ-023 A simultaneous input and output transfer SHALL leave count unchanged and advance both pointers.
REQ-024 When full, an output transfer SHALL raise in_ready only in the following cycle.
REQ-025 When empty with FALLTHROUGH=0, out_valid SHALL stay low even if in_valid is high.
REQ-026 flush SHALL dominate: in the flush cycle no transfer occurs on either side; at the next edge count, both pointers, and full SHALL become 0 and empty SHALL become 1.
REQ-027 Payload storage contents SHALL need no reset; out_bus is don't-care while out_valid is low.

Reset
REQ-028 While rst_n is low, count, read pointer, and write pointer SHALL be 0, out_valid and full SHALL be 0, and empty SHALL be 1, independent of clk.
REQ-029 in_ready SHALL be 0 while rst_n is low and SHALL become 1 in the first cycle after rst_n deasserts.
REQ-030 Assertion of rst_n mid-operation SHALL discard all entries immediately, with no partial transfer completing.

Structure
REQ-031 The stage-bus width constants (ADDR_WIDTH, DATA_WIDTH, REG_ADDR_WIDTH, and derived per-link widths such as 2*DATA_WIDTH for IF->ID) SHALL live in a shared package used by the stage modules and the pipe_buf instances.
REQ-032 pipe_buf SHALL be self-contained; the storage array MAY be one sub-module, pipe_buf_ram (a DEPTH x DATA_WIDTH register array with one write and one read port).

Verification
REQ-033 After reset, DEPTH=2, FALLTHROUGH=0: push 0xA then 0xB with out_ready=0 -> count=2, full=1, in_ready=0; assert out_ready -> 0xA then 0xB are delivered, then empty=1.
REQ-034 DEPTH=4: stream 10 words 0..9 with out_ready toggling every cycle -> output sequence is 0..9 in order, with pointer wrap and no loss or duplication.
REQ-035 FALLTHROUGH=1, empty, in_valid=1, in_bus=0x55, out_ready=1 -> out_valid=1 and out_bus=0x55 in the same cycle, with count remaining 0.
REQ-036 Full buffer with simultaneous out_ready=1 and in_valid=1 -> no input is accepted that cycle; one entry leaves, count=DEPTH-1, and in_ready=1 in the next cycle.
REQ-037 count=3 of 4, then flush=1 with in_valid=1 -> no transfer; next cycle count=0, empty=1, out_valid=0.
REQ-038 rst_n driven low between clock edges with count=2 -> count=0 and out_valid=0 immediately, before the next edge.
